conv_window_gen: RTL
====================

Name: conv_window_gen

Overview:
- Upstream feeder for the conv/ReLU/max-pool stage. Accepts a raster-order stream of 8-bit pixels for one IMG_W x IMG_H image.
- Emits one 72-bit 3x3 window per valid convolution position, (IMG_W-2) x (IMG_H-2) windows per frame. These drive the convolution input data/valid pair directly.
- Built from two internal line buffers, a 3x3 window register, position counters and a small FSM.
- Frames arrive back-to-back with no gap required.

Parameters:
- IMG_W, 28, pixels per image row (minimum 3).
- IMG_H, 28, rows per image (minimum 3).
- PIX_W, 8, bits per pixel; o_data is 9*PIX_W wide.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_pixel_data  in  PIX_W  input pixel, raster order: row 0 col 0 first.
- i_pixel_data_valid  in  1  pixel accepted on every cycle this is high. There is no backpressure.
- o_data  out  9*PIX_W  3x3 window. Element (r,c), with r=0 as the oldest row and c=0 as the leftmost column, sits at bits [PIX_W*(3r+c)+PIX_W-1 : PIX_W*(3r+c)].
- o_data_valid  out  1  one-cycle qualifier per window.
- o_frame_done  out  1  one-cycle pulse, coincident with the last window of a frame.

Behaviour:
- Reset: o_data=0, o_data_valid=0, o_frame_done=0, col=0, row=0, FSM=S_FILL.
  - Line-buffer contents need no clearing; they are never emitted before being rewritten.
- Counters:
  - col (0..IMG_W-1) increments on each accepted pixel and wraps to 0.
  - row (0..IMG_H-1) increments on col wrap.
  - After (IMG_H-1, IMG_W-1), both return to 0 and a new frame starts.
- Line buffers:
  - LB1 holds the previous row and LB0 the row before it, each IMG_W deep and indexed by col.
  - On an accepted pixel at col: read LB0[col] and LB1[col], write LB0[col]<=LB1[col] and LB1[col]<=pixel in the same cycle. Read returns the old data.
- Window register:
  - On each accepted pixel, columns shift left.
  - The new right column is {LB0[col], LB1[col], pixel}, loaded as rows 0,1,2.
  - The window register does not change on cycles with valid low.
- FSM:
  - S_FILL: row<2; no output. Transitions to S_RUN when the last pixel of row 1 is accepted.
  - S_RUN: rows 2..IMG_H-1. Transitions to S_FILL when the last pixel of the frame is accepted.
- Output:
  - If in S_RUN and col>=2 when a pixel is accepted, the next cycle shows o_data_valid=1 and the new window on o_data. Latency is 1 cycle from the bottom-right pixel.
  - Otherwise o_data_valid=0 and o_data holds its last value.
  - o_frame_done=1 in the same cycle as the window whose bottom-right pixel is (IMG_H-1, IMG_W-1).
- Stall tolerance: gaps in i_pixel_data_valid of any length and at any position are transparent. Output values and counts are identical, only delayed.
- Row wrap: windows never straddle rows, because cols 0 and 1 of each row emit nothing.
- Reset mid-frame: all counters and the FSM return to reset state next cycle, and no window is emitted for the partial frame. The next pixel accepted is treated as (0,0).
- Reset dominates i_pixel_data_valid in the same cycle.

Decomposition:
- Shared package holds IMG_W/IMG_H/PIX_W defaults and the FSM state encoding (S_FILL, S_RUN).
- One natural sub-module: line_buffer_rw, a single-port-per-cycle IMG_W x PIX_W RAM with read-old-write semantics, instantiated twice.
- Counters, FSM and window register stay in the top.

Test Plan:
- Single frame, continuous valid, pixel = (row*28+col) mod 256:
  - First o_data_valid occurs 1 cycle after pixel index 58 is accepted.
  - Elements 0..8 are 0,1,2,28,29,30,56,57,58.
  - Exactly 676 windows are emitted.
  - The last window's bottom-right element is 783 mod 256 = 0x0F, and o_frame_done is high with it.
- Same frame with random 0-5 cycle valid gaps: the window sequence is identical to the continuous case and there are 676 valid pulses.
- Two back-to-back frames:
  - The second frame's first window appears after its own pixel 58.
  - No window mixes frame 1 rows into frame 2.
  - Exactly 2 frame_done pulses.
- Row boundary check: the window after (2,27) has bottom-right (3,2) = 86. No valid is emitted for cols 0,1 of row 3.
- Reset asserted after pixel 300 and then a full frame sent: no output from the partial frame, then exactly 676 correct windows with first element 0.
- IMG_W=5, IMG_H=4 with pixel = index: 6 windows emitted. The first is {0,1,2,5,6,7,10,11,12} and the last is {7,8,9,12,13,14,17,18,19} with frame_done.

Source files
------------

// File: rtl/conv_window_gen_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_window_gen_pkg : shared defaults and FSM encoding for conv_window_gen
// Revision 1.0
// ---------------------------------------------------------------------------
package conv_window_gen_pkg;

  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;
  localparam int PIX_W_DEF = 8;

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_window_gen_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_window_gen_if : pixel stream in, 3x3 window stream out
// Revision 1.0
// ---------------------------------------------------------------------------
interface conv_window_gen_if
  import conv_window_gen_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
);
  logic [PIX_W-1:0]   i_pixel_data;
  logic               i_pixel_data_valid;
  logic [9*PIX_W-1:0] o_data;
  logic               o_data_valid;
  logic               o_frame_done;

  modport master (
    output i_pixel_data, i_pixel_data_valid,
    input  o_data, o_data_valid, o_frame_done
  );

  modport slave (
    input  i_pixel_data, i_pixel_data_valid,
    output o_data, o_data_valid, o_frame_done
  );
endinterface
`default_nettype wire

// File: rtl/conv_window_gen_line_buffer_rw.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_window_gen_line_buffer_rw : DEPTH x WIDTH row store, read-old-write
// Revision 1.0
// ---------------------------------------------------------------------------
module conv_window_gen_line_buffer_rw #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             we,
  input  wire logic [AW-1:0]    addr,
  input  wire logic [WIDTH-1:0] wdata,
  output logic      [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Asynchronous read: the value seen this cycle is the pre-write contents.
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_window_gen : raster pixel stream to 3x3 convolution windows
// Revision 1.0
// ---------------------------------------------------------------------------
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input wire logic        i_clk,
  input wire logic        i_rst,
  conv_window_gen_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  state_t        state, state_nx;

  // Packed [r][c][bit] places element (r,c) at PIX_W*(3r+c) when flattened.
  logic [2:0][2:0][PIX_W-1:0] win, win_nx;
  logic [PIX_W-1:0]           lb0_rd, lb1_rd;
  logic [9*PIX_W-1:0]         data_q;
  logic                       valid_q, done_q;

  logic accept, col_last, row_last, emit;

  assign accept   = bus.i_pixel_data_valid && !i_rst;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign emit     = accept && (state == S_RUN) && (col >= CW'(2));

  conv_window_gen_line_buffer_rw #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk   (i_clk),
    .we    (accept),
    .addr  (col),
    .wdata (lb1_rd),
    .rdata (lb0_rd)
  );

  conv_window_gen_line_buffer_rw #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk   (i_clk),
    .we    (accept),
    .addr  (col),
    .wdata (bus.i_pixel_data),
    .rdata (lb1_rd)
  );

  always_comb begin
    win_nx = win;
    for (int r = 0; r < 3; r++) begin
      win_nx[r][0] = win[r][1];
      win_nx[r][1] = win[r][2];
    end
    win_nx[0][2] = lb0_rd;
    win_nx[1][2] = lb1_rd;
    win_nx[2][2] = bus.i_pixel_data;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FILL:  if (accept && col_last && (row == RW'(1))) state_nx = S_RUN;
      S_RUN:   if (accept && col_last && row_last)        state_nx = S_FILL;
      default: state_nx = S_FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col     <= '0;
      row     <= '0;
      state   <= S_FILL;
      win     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      valid_q <= emit;
      done_q  <= emit && row_last && col_last;
      if (accept) begin
        win <= win_nx;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (emit) begin
        data_q <= win_nx;
      end
    end
  end

  assign bus.o_data       = data_q;
  assign bus.o_data_valid = valid_q;
  assign bus.o_frame_done = done_q;

endmodule
`default_nettype wire
